// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : matrix_scan_ctrl
// Purpose : Double-buffered 8x8 RGB frame store and row-word scan scheduler
//           feeding a 74HC595 shifter over valid/ready.
//           Optional MATRIX_SCAN_COLOR_SEQ_EN: send R, B, G as separate words.
// Revision: 1.0 - initial release
// ============================================================================
module matrix_scan_ctrl #(
    parameter int DWELL_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [5:0]  wr_addr,
    input  logic [2:0]  wr_rgb,
    input  logic        swap_req,
    output logic        swap_done,
    output logic        active_bank,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] word_data,
    output logic        frame_start
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_DWELL  = 2'd2
    } state_t;

    localparam logic [15:0] c_dwell_load = 16'(DWELL_CYCLES - 1);

    state_t      r_state;
    logic        r_active_bank;
    logic        r_swap_pending;
    logic [2:0]  r_bank [0:1][0:63];
    logic [2:0]  r_row;
    logic [15:0] r_cnt;
    logic        r_word_valid;
    logic [31:0] r_word_data;

    logic        w_dwell_done;
    logic        w_last;
    logic        w_first;
    logic        w_do_swap;
    logic        w_front;
    logic        w_wr_fire;
    logic [2:0]  w_nrow;
    logic [2:0]  w_pix [0:7];
    logic [7:0]  w_red_n;
    logic [7:0]  w_grn_n;
    logic [7:0]  w_blu_n;
    logic [7:0]  w_anode;
    logic [31:0] w_word;

`ifdef MATRIX_SCAN_COLOR_SEQ_EN
    logic [1:0]  r_phase;
    logic [1:0]  w_nphase;

    assign w_last  = (r_row == 3'd7) && (r_phase == 2'd2);
    assign w_first = (r_row == 3'd0) && (r_phase == 2'd0);

    // Index of the word about to be built: restart in IDLE, else step R->B->G then next row
    always_comb begin
        w_nrow   = 3'd0;
        w_nphase = 2'd0;
        if (r_state != ST_IDLE) begin
            if (r_phase == 2'd2) begin
                w_nrow   = r_row + 3'd1;
                w_nphase = 2'd0;
            end else begin
                w_nrow   = r_row;
                w_nphase = r_phase + 2'd1;
            end
        end
    end

    always_comb begin
        case (w_nphase)
            2'd0:    w_word = {w_red_n, 8'hFF, 8'hFF, w_anode};
            2'd1:    w_word = {8'hFF, w_blu_n, 8'hFF, w_anode};
            default: w_word = {8'hFF, 8'hFF, w_grn_n, w_anode};
        endcase
    end
`else
    assign w_last  = (r_row == 3'd7);
    assign w_first = (r_row == 3'd0);
    assign w_nrow  = (r_state == ST_IDLE) ? 3'd0 : r_row + 3'd1;
    assign w_word  = {w_red_n, w_blu_n, w_grn_n, w_anode};
`endif

    assign w_dwell_done = (r_state == ST_DWELL) && (r_cnt == 16'd0);
    assign w_do_swap    = r_swap_pending &&
                          ((r_state == ST_IDLE) || (w_dwell_done && w_last));
    // Next word is always built from the bank that will be front after this edge
    assign w_front      = r_active_bank ^ w_do_swap;
    assign w_wr_fire    = wr_valid && !r_swap_pending;
    assign w_anode      = 8'h80 >> w_nrow;

    generate
        for (genvar c = 0; c < 8; c++) begin : g_col
            assign w_pix[c]       = r_bank[w_front][{w_nrow, 3'(c)}];
            assign w_red_n[7 - c] = ~w_pix[c][2];
            assign w_grn_n[7 - c] = ~w_pix[c][1];
            assign w_blu_n[7 - c] = ~w_pix[c][0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < 64; a++) begin
                    r_bank[b][a] <= 3'b000;
                end
            end
        end else if (w_wr_fire) begin
            r_bank[~r_active_bank][wr_addr] <= wr_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_active_bank  <= 1'b0;
            r_swap_pending <= 1'b0;
            r_row          <= 3'd0;
`ifdef MATRIX_SCAN_COLOR_SEQ_EN
            r_phase        <= 2'd0;
`endif
            r_cnt          <= 16'd0;
            r_word_valid   <= 1'b0;
            r_word_data    <= 32'hFFFF_FF00;
        end else begin
            if (w_do_swap) begin
                r_active_bank <= ~r_active_bank;
            end
            // A request arriving while one is already pending is absorbed
            r_swap_pending <= w_do_swap ? 1'b0 : (r_swap_pending | swap_req);

            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_row        <= w_nrow;
`ifdef MATRIX_SCAN_COLOR_SEQ_EN
                        r_phase      <= w_nphase;
`endif
                        r_word_data  <= w_word;
                        r_word_valid <= 1'b1;
                        r_state      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (word_ready) begin
                        r_word_valid <= 1'b0;
                        r_cnt        <= c_dwell_load;
                        r_state      <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (enable) begin
                        r_row        <= w_nrow;
`ifdef MATRIX_SCAN_COLOR_SEQ_EN
                        r_phase      <= w_nphase;
`endif
                        r_word_data  <= w_word;
                        r_word_valid <= 1'b1;
                        r_state      <= ST_LAUNCH;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_ready    = !r_swap_pending;
    assign swap_done   = w_do_swap;
    assign active_bank = r_active_bank;
    assign word_valid  = r_word_valid;
    assign word_data   = r_word_data;
    assign frame_start = (r_state == ST_LAUNCH) && word_ready && w_first;

endmodule
`default_nettype wire
